reg_file_8x8: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/reg_read_port.sv | 29 ++
 rtl/reg_file_8x8.sv | 68 ++++++
 tb/tb_reg_file_8x8.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath constants and types for the register file and its read ports.
// Delay constants document the intended read/write timing; the RTL itself is zero-delay.
package cpu_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 3;
  localparam int unsigned REG_COUNT = 2 ** ADDR_W;
  localparam int unsigned RD_DELAY  = 2;
  localparam int unsigned WR_DELAY  = 1;

  localparam logic [DATA_W-1:0] REG_RESET_VAL = 8'h00;

  typedef logic [REG_COUNT-1:0][DATA_W-1:0] reg_array_t;

endpackage

// File: rtl/reg_read_port.sv
// One asynchronous read port: REG_COUNT-to-1 mux over the register array.
// With REG_BYPASS_EN defined, a pending write to the addressed register is forwarded.
module reg_read_port
  import cpu_pkg::*;
(
  input  reg_array_t        regs_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] data_o
);

`ifdef REG_BYPASS_EN
  always_comb begin
    data_o = regs_i[addr_i];
    // Forward write data so the port already shows what the next edge will store.
    if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};

  assign data_o = regs_i[addr_i];
`endif

endmodule

// File: rtl/reg_file_8x8.sv
// Eight-entry, 8-bit register file with two asynchronous read ports and a zero flag.
// Define REG_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_8x8
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              ZERO_IN,
  input  logic              FLAGWRITE,
  output logic              ZERO_FLAG
);

  reg_array_t regs_d, regs_q;
  logic       zero_flag_d, zero_flag_q;
  logic       wr_en;

  // Reset wins over a write in the same cycle, so it also suppresses forwarding.
  assign wr_en = WRITE & ~RESET;

  always_comb begin
    regs_d      = regs_q;
    zero_flag_d = zero_flag_q;
    if (WRITE) begin
      regs_d[INADDRESS] = IN;
    end
    if (FLAGWRITE) begin
      zero_flag_d = ZERO_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs_q      <= {REG_COUNT{REG_RESET_VAL}};
      zero_flag_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      zero_flag_q <= zero_flag_d;
    end
  end

  reg_read_port u_read_port1 (
    .regs_i    (regs_q),
    .addr_i    (OUT1ADDRESS),
    .wr_en_i   (wr_en),
    .wr_addr_i (INADDRESS),
    .wr_data_i (IN),
    .data_o    (OUT1)
  );

  reg_read_port u_read_port2 (
    .regs_i    (regs_q),
    .addr_i    (OUT2ADDRESS),
    .wr_en_i   (wr_en),
    .wr_addr_i (INADDRESS),
    .wr_data_i (IN),
    .data_o    (OUT2)
  );

  assign ZERO_FLAG = zero_flag_q;

endmodule

// File: tb/tb_reg_file_8x8.sv
// Self-checking bench for reg_file_8x8: directed scenarios plus randomized traffic
// checked every cycle against an array model of the register file.
module tb_reg_file_8x8;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [2:0] waddr;
  logic       wen;
  logic [2:0] a1, a2;
  logic [7:0] out1, out2;
  logic       zin, fw, zflag;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_regs [8];
  logic       m_flag;
  logic       m_valid = 1'b0;

  reg_file_8x8 dut (
    .CLK         (clk),
    .RESET       (rst),
    .IN          (din),
    .INADDRESS   (waddr),
    .WRITE       (wen),
    .OUT1ADDRESS (a1),
    .OUT2ADDRESS (a2),
    .OUT1        (out1),
    .OUT2        (out2),
    .ZERO_IN     (zin),
    .FLAGWRITE   (fw),
    .ZERO_FLAG   (zflag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: state changes only at a rising edge, reset first.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= 8'h00;
      m_flag  <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      if (wen) m_regs[waddr] <= din;
      if (fw) m_flag <= zin;
    end
  end

  function automatic logic [7:0] exp_read(input logic [2:0] a);
    logic [7:0] v;
    v = m_regs[a];
`ifdef REG_BYPASS_EN
    if (wen && !rst && (waddr == a)) v = din;
`endif
    return v;
  endfunction

  // Every-cycle comparison against the model, mid-cycle away from the edge.
  always @(negedge clk) begin
    if (m_valid) begin
      total++;
      if (out1 !== exp_read(a1)) begin
        bad++;
        $display("FAIL model_out1 addr=%0d got=%h want=%h t=%0t", a1, out1, exp_read(a1), $time);
      end
      total++;
      if (out2 !== exp_read(a2)) begin
        bad++;
        $display("FAIL model_out2 addr=%0d got=%h want=%h t=%0t", a2, out2, exp_read(a2), $time);
      end
      total++;
      if (zflag !== m_flag) begin
        bad++;
        $display("FAIL model_flag got=%b want=%b t=%0t", zflag, m_flag, $time);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wen = 1'b0; fw = 1'b0; zin = 1'b0;
  endtask

  initial begin
    logic [7:0] sum;
    // Reset priority: write and flag capture in the reset cycle are discarded.
    rst = 1'b1; wen = 1'b1; waddr = 3'd1; din = 8'hFF; fw = 1'b1; zin = 1'b1;
    a1 = 3'd1; a2 = 3'd0;
    cyc();
    idle();
    @(negedge clk);
    chk("reset_prio_r1", out1, 8'h00);
    chk("reset_prio_flag", {7'd0, zflag}, 8'h00);

    // Consecutive writes, then read both back.
    wen = 1'b1; waddr = 3'd3; din = 8'h5A;
    cyc();
    waddr = 3'd6; din = 8'hA5;
    cyc();
    wen = 1'b0; a1 = 3'd3; a2 = 3'd6;
    @(negedge clk);
    chk("write_r3", out1, 8'h5A);
    chk("write_r6", out2, 8'hA5);
    cyc();
    a1 = 3'd0; a2 = 3'd7;
    @(negedge clk);
    chk("untouched_r0", out1, 8'h00);
    chk("untouched_r7", out2, 8'h00);

    // Same-cycle read and write of r2.
    cyc();
    wen = 1'b1; waddr = 3'd2; din = 8'h11;
    cyc();
    din = 8'h22; a1 = 3'd2;
    @(negedge clk);
`ifdef REG_BYPASS_EN
    chk("rw_same_before_edge", out1, 8'h22);
`else
    chk("rw_same_before_edge", out1, 8'h11);
`endif
    cyc();
    wen = 1'b0;
    @(negedge clk);
    chk("rw_same_after_edge", out1, 8'h22);

    // Zero flag capture and hold.
    cyc();
    fw = 1'b1; zin = 1'b1;
    cyc();
    fw = 1'b0; zin = 1'b0;
    @(negedge clk);
    chk("flag_set", {7'd0, zflag}, 8'h01);
    cyc();
    @(negedge clk);
    chk("flag_hold", {7'd0, zflag}, 8'h01);

    // ALU loop: r1 + r2 written back to r4, flag from the sum.
    cyc();
    wen = 1'b1; waddr = 3'd1; din = 8'h05;
    cyc();
    waddr = 3'd2; din = 8'h03;
    cyc();
    wen = 1'b0; a1 = 3'd1; a2 = 3'd2;
    cyc();
    sum = out1 + out2;
    wen = 1'b1; waddr = 3'd4; din = sum; fw = 1'b1; zin = (sum == 8'h00);
    cyc();
    idle();
    a1 = 3'd4;
    @(negedge clk);
    chk("alu_add_r4", out1, 8'h08);
    chk("alu_add_flag", {7'd0, zflag}, 8'h00);
    cyc();
    wen = 1'b1; waddr = 3'd1; din = 8'hFB;
    cyc();
    waddr = 3'd2; din = 8'h05;
    cyc();
    wen = 1'b0; a1 = 3'd1; a2 = 3'd2;
    cyc();
    sum = out1 + out2;
    wen = 1'b1; waddr = 3'd4; din = sum; fw = 1'b1; zin = (sum == 8'h00);
    cyc();
    idle();
    a1 = 3'd4;
    @(negedge clk);
    chk("alu_wrap_r4", out1, 8'h00);
    chk("alu_wrap_flag", {7'd0, zflag}, 8'h01);

    // Randomized traffic with occasional mid-sequence resets.
    for (int n = 0; n < 400; n++) begin
      cyc();
      rst   = ($urandom_range(0, 31) == 0);
      wen   = $urandom_range(0, 1);
      waddr = 3'($urandom_range(0, 7));
      din   = 8'($urandom);
      a1    = 3'($urandom_range(0, 7));
      a2    = 3'($urandom_range(0, 7));
      fw    = $urandom_range(0, 1);
      zin   = $urandom_range(0, 1);
    end

    // Reset after random writes clears every register and the flag.
    cyc();
    idle();
    for (int i = 0; i < 8; i++) begin
      wen = 1'b1; waddr = 3'(i); din = 8'(8'h81 + i);
      cyc();
    end
    wen = 1'b0; fw = 1'b1; zin = 1'b1;
    cyc();
    rst = 1'b1; fw = 1'b0; zin = 1'b0;
    cyc();
    idle();
    for (int i = 0; i < 8; i++) begin
      a1 = 3'(i); a2 = 3'(7 - i);
      @(negedge clk);
      chk("reset_all_p1", out1, 8'h00);
      chk("reset_all_p2", out2, 8'h00);
      cyc();
    end
    @(negedge clk);
    chk("reset_all_flag", {7'd0, zflag}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
